// File: rtl/pattern_pkg.sv
// Shared types and sizing helpers for the pattern serializer and its neighbours.
package pattern_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int WIDTH_DEF = 8;

  // Bit-counter width for a WIDTH-bit word; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/pattern_serializer.sv
// Purpose: parallel-to-serial feeder, one bit per clock, gapless across words.
// Latency: first bit valid the cycle after the accept edge; a word spans WIDTH cycles.
// Backpressure: in_ready only when idle or on the last bit; abort flushes and refuses input.
module pattern_serializer
  import pattern_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             abort,
  output logic             ser_data,
  output logic             ser_valid,
  output logic             busy,
  output logic             word_done
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             accept;

  // Serial outputs decode from registers only.
  assign ser_valid = (state == ST_SHIFT);
  assign busy      = ser_valid;
  assign word_done = ser_valid && (cnt == LAST);
  assign ser_data  = ser_valid ? (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]) : IDLE_LEVEL;

  assign in_ready = !reset && !abort && ((state == ST_IDLE) || word_done);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cnt_n   = cnt;
    if (abort) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state_n = ST_SHIFT;
            shreg_n = in_data;
            cnt_n   = '0;
          end
        end
        ST_SHIFT: begin
          if (cnt != LAST) begin
            cnt_n   = cnt + 1'b1;
            shreg_n = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
          end else if (accept) begin
            shreg_n = in_data;
            cnt_n   = '0;
          end else begin
            state_n = ST_IDLE;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      shreg <= shreg_n;
      cnt   <= cnt_n;
    end
  end

endmodule

// File: tb/tb_pattern_serializer.sv
// Bench for pattern_serializer: MSB-first and LSB-first instances share stimulus,
// checked against a bit-queue model of the serial stream.
module tb_pattern_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       abort;

  logic m_ready, m_data, m_valid, m_busy, m_done;
  logic l_ready, l_data, l_valid, l_busy, l_done;

  int total = 0;
  int bad   = 0;

  // Pending serial bits per instance; index 0 is the bit on the line now.
  bit qm[$];
  bit ql[$];
  logic [15:0] cap_m, cap_l;

  always #5 clk = ~clk;

  pattern_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_m (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(m_ready), .abort(abort), .ser_data(m_data), .ser_valid(m_valid),
    .busy(m_busy), .word_done(m_done)
  );

  pattern_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_l (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(l_ready), .abort(abort), .ser_data(l_data), .ser_valid(l_valid),
    .busy(l_busy), .word_done(l_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string tag, input bit q[$], input logic rdy_exp,
                             input logic rdy, input logic d, input logic v,
                             input logic b, input logic wd);
    logic ev;
    ev = (q.size() > 0);
    chk({tag, ".in_ready"},  rdy, rdy_exp);
    chk({tag, ".ser_valid"}, v,   ev);
    chk({tag, ".busy"},      b,   ev);
    chk({tag, ".ser_data"},  d,   ev ? q[0] : 1'b0);
    chk({tag, ".word_done"}, wd,  q.size() == 1);
  endtask

  // One clock: drive at negedge, check against the model, advance the model at posedge.
  task automatic cyc(input logic v, input logic [7:0] d, input logic ab);
    logic rdy_exp, acc;
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    abort    = ab;
    #1;
    rdy_exp = !ab && (qm.size() <= 1);
    chk_outputs("msb", qm, rdy_exp, m_ready, m_data, m_valid, m_busy, m_done);
    chk_outputs("lsb", ql, rdy_exp, l_ready, l_data, l_valid, l_busy, l_done);
    if (m_valid) cap_m = {cap_m[14:0], m_data};
    if (l_valid) cap_l = {cap_l[14:0], l_data};
    acc = v && rdy_exp;
    @(posedge clk);
    if (ab) begin
      qm.delete();
      ql.delete();
    end else begin
      if (qm.size() > 0) void'(qm.pop_front());
      if (ql.size() > 0) void'(ql.pop_front());
      if (acc) begin
        for (int i = 0; i < 8; i++) begin
          qm.push_back(d[7-i]);
          ql.push_back(d[i]);
        end
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    in_data  = 8'h00;
    in_valid = 1'b0;
    abort    = 1'b0;
    #3;
    chk("rst.ser_valid", m_valid, 1'b0);
    chk("rst.busy",      m_busy,  1'b0);
    chk("rst.word_done", m_done,  1'b0);
    chk("rst.ser_data",  m_data,  1'b0);
    chk("rst.in_ready",  m_ready, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rel.in_ready", m_ready, 1'b1);

    // Single word, MSB first: 0,1,0,0,1,0,1,0.
    cap_m = '0;
    cyc(1'b1, 8'h4A, 1'b0);
    for (int i = 0; i < 9; i++) cyc(1'b0, 8'h00, 1'b0);
    chk("word_4A.bits", cap_m[7:0], 8'h4A);

    // Back-to-back words with in_valid held high.
    cap_m = '0;
    cyc(1'b1, 8'hA5, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'h3C, 1'b0);
    for (int i = 0; i < 9; i++) cyc(1'b0, 8'h00, 1'b0);
    chk("stream.bits", cap_m, 16'hA53C);

    // LSB-first instance sends bit 0 first.
    cap_l = '0;
    cyc(1'b1, 8'h01, 1'b0);
    for (int i = 0; i < 9; i++) cyc(1'b0, 8'h00, 1'b0);
    chk("lsb_01.bits", cap_l[7:0], 8'h80);

    // Asynchronous reset during the third bit.
    cyc(1'b1, 8'hFF, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("arst.ser_valid", m_valid, 1'b0);
    chk("arst.busy",      m_busy,  1'b0);
    chk("arst.ser_data",  m_data,  1'b0);
    chk("arst.in_ready",  m_ready, 1'b0);
    chk("arst.l_valid",   l_valid, 1'b0);
    qm.delete();
    ql.delete();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("arst_rel.in_ready", m_ready, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b0);

    // Abort at bit 5 with a new word waiting; it is taken only the cycle after.
    cyc(1'b1, 8'hC3, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b1, 8'h96, 1'b1);
    cap_m = '0;
    cyc(1'b1, 8'h96, 1'b0);
    for (int i = 0; i < 9; i++) cyc(1'b0, 8'h00, 1'b0);
    chk("abort.next_word", cap_m[7:0], 8'h96);

    // in_data churns while shifting; only the accepted word appears.
    cap_m = '0;
    cyc(1'b1, 8'h5E, 1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'($urandom), 1'b0);
    chk("churn.bits", cap_m[7:0], 8'h5E);

    // Randomized traffic with occasional aborts.
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 19) == 0));
    end
    for (int i = 0; i < 10; i++) cyc(1'b0, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pattern_serializer.md
Name: pattern_serializer

Overview:
Parallel-to-serial feeder that sits directly upstream of the serial pattern-detection FSMs. It accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per clock on a serial data line, together with a bit-valid qualifier. Back-to-back words stream with no idle gap, so a detector sees a continuous bitstream across word boundaries.

Parameters:
WIDTH, 8, bits per word; legal range is 2 to 32.
MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
IDLE_LEVEL, 0, value driven on ser_data while no word is being shifted.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
in_data  input  WIDTH  parallel word, sampled only on the accept cycle.
in_valid  input  1  upstream has a word on in_data.
in_ready  output  1  block can accept a word this cycle.
abort  input  1  synchronous flush; drops the word in flight.
ser_data  output  1  serial bit to the downstream detector's data input.
ser_valid  output  1  ser_data carries a real bit this cycle.
busy  output  1  a word is being shifted (same as ser_valid).
word_done  output  1  high during the last bit of each word.

Behaviour:
- Internal state:
  - 2-state FSM: ST_IDLE, ST_SHIFT.
  - Shift register shreg[WIDTH-1:0].
  - Bit counter cnt, $clog2(WIDTH) bits wide.
- Reset is asynchronous and active-high. It forces ST_IDLE, shreg=0, cnt=0 immediately. While reset is high: ser_valid=0, busy=0, word_done=0, ser_data=IDLE_LEVEL, in_ready=0.
- Output decode, from registers only (no combinational path from in_data, in_valid or abort to the serial outputs):
  - ser_valid = busy = (state==ST_SHIFT).
  - ser_data = shreg[WIDTH-1] when MSB_FIRST=1, shreg[0] when MSB_FIRST=0, but only in ST_SHIFT; otherwise IDLE_LEVEL.
  - word_done = (state==ST_SHIFT) && (cnt==WIDTH-1).
- in_ready:
  - in_ready = !reset && !abort && ((state==ST_IDLE) || word_done).
  - Accept = in_valid && in_ready.
- Transitions:
  - ST_IDLE, accept -> ST_SHIFT; shreg<=in_data; cnt<=0.
  - ST_IDLE, no accept -> stay in ST_IDLE.
  - ST_SHIFT, cnt<WIDTH-1 -> cnt<=cnt+1. Shift shreg by one toward the output end: left when MSB_FIRST=1, right when MSB_FIRST=0, filling with 0.
  - ST_SHIFT, cnt==WIDTH-1 with accept -> stay in ST_SHIFT; shreg<=in_data; cnt<=0. This gives a gapless back-to-back stream.
  - ST_SHIFT, cnt==WIDTH-1 without accept -> ST_IDLE.
  - abort=1 in any state -> ST_IDLE, cnt<=0 next edge. abort has priority over accept; no word is taken in an abort cycle.
- Latency: a word accepted on edge N has its first bit valid in the cycle after edge N. The word occupies exactly WIDTH consecutive ser_valid cycles.
- Throughput: 1 bit/clk sustained; one word per WIDTH cycles at most.
- in_valid asserted while in_ready=0 is not an accept. in_data changes during shifting have no effect.
- Reset or abort mid-word discards the remaining bits; no partial word is resumed.
- After reset deasserts, in_ready=1 in the first cycle, unless abort is high.

Decomposition:
- Shared package pattern_pkg holds:
  - the state typedef state_t {ST_IDLE, ST_SHIFT};
  - the localparam default for WIDTH;
  - a cnt-width helper function.
- No sub-module is required; counter and shift register stay inline.

Test Plan:
- WIDTH=8, MSB_FIRST=1, accept 8'h4A. Expected ser_data over the 8 valid cycles: 0,1,0,0,1,0,1,0. word_done high on the 8th cycle only, then ser_valid=0 and ser_data=0. When chained to the downstream detector, that detector flags the 010 pattern.
- in_valid held high with 8'hA5 followed by 8'h3C. Expected: 16 contiguous ser_valid cycles carrying 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0. in_ready high only in cycles 8 and 16, and in the initial idle cycle.
- MSB_FIRST=0, accept 8'h01. Expected: the first serial bit is 1, the next 7 are 0.
- Assert reset asynchronously during the 3rd bit. Expected: ser_valid and busy drop to 0 without waiting for a clock edge. After release, no residual bits appear and in_ready=1.
- Pulse abort for 1 cycle at bit 5, with in_valid=1 and a new word present. Expected: ST_IDLE next cycle and the new word is not accepted that cycle. The following cycle the word is accepted and its first bit appears one cycle later.
- Change in_data every cycle while a word is shifting, with in_ready=0. Expected: the serial output matches the originally accepted word bit-for-bit.
